// File: rtl/arbiter_pkg.sv
// Shared constants and sequencer state type for the event readout controller.
package arbiter_pkg;
   localparam int ROWS_DEFAULT = 8;
   localparam int COLS_DEFAULT = 8;
   localparam int X_W = $clog2(COLS_DEFAULT);
   localparam int Y_W = $clog2(ROWS_DEFAULT);

   typedef enum logic [2:0] {IDLE, SETTLE, SCAN, EMIT, ROW_DONE} rd_state_t;
endpackage

// File: rtl/event_readout_ctrl_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request after index 'last'.
module rr_pick #(
   parameter  int N  = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant
);
   logic found;

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      found = 1'b0;
      // Offset 1..N wraps back to 'last' itself, so a lone requester can win again.
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/event_readout_ctrl.sv
// Event-camera readout sequencer: round-robin row visit, column scan, timestamped event stream.
// state    | meaning
// IDLE     | no row selected, waiting for enable and a row request
// SETTLE   | row selected, waiting for column requests to settle
// SCAN     | pick lowest unserved column, or finish the row
// EMIT     | event presented, waiting for downstream ready
// ROW_DONE | deselect row, clear per-visit state, advance round-robin
module event_readout_ctrl
   import arbiter_pkg::*;
#(
   parameter int ROWS       = ROWS_DEFAULT,
   parameter int COLS       = COLS_DEFAULT,
   parameter int SETTLE_CYC = 2,
   parameter int MAX_BURST  = 4,
   parameter int TS_W       = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enable_i,
   input  logic [ROWS-1:0]         row_req_i,
   input  logic [COLS-1:0]         col_req_i,
   output logic [ROWS-1:0]         row_sel_o,
   output logic [COLS-1:0]         pixel_ack_o,
   output logic                    evt_valid_o,
   input  logic                    evt_ready_i,
   output logic [$clog2(COLS)-1:0] evt_x_o,
   output logic [$clog2(ROWS)-1:0] evt_y_o,
   output logic [TS_W-1:0]         evt_ts_o,
   output logic                    busy_o
);
   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   rd_state_t       state_q, state_d;
   logic [ROWS-1:0] row_grant, row_sel_q;
   logic [YW-1:0]   grant_idx, y_q, rr_ptr_q, evt_y_q;
   logic [SW-1:0]   settle_q;
   logic [COLS-1:0] served_q, cand, ack_q;
   logic [BW-1:0]   burst_q;
   logic [XW-1:0]   pick_x, evt_x_q;
   logic [TS_W-1:0] ts_cnt, evt_ts_q;
   logic            load_row, capture, handshake;

   rr_pick #(.N(ROWS)) u_rr_pick (
      .req   (row_req_i),
      .last  (rr_ptr_q),
      .grant (row_grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < ROWS; i++)
         if (row_grant[i]) grant_idx = YW'(i);
   end

   // Already-served pixels are masked so a slow-clearing request is not emitted twice.
   assign cand = col_req_i & ~served_q;

   always_comb begin
      pick_x = '0;
      for (int i = COLS - 1; i >= 0; i--)
         if (cand[i]) pick_x = XW'(i);
   end

   always_comb begin
      state_d   = state_q;
      load_row  = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i && |row_req_i) begin
               load_row = 1'b1;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == '0) state_d = SCAN;
         end
         SCAN: begin
            if (enable_i && |cand) begin
               capture = 1'b1;
               state_d = EMIT;
            end else begin
               state_d = ROW_DONE;
            end
         end
         EMIT: begin
            if (evt_ready_i) begin
               handshake = 1'b1;
               state_d   = (burst_q == BW'(MAX_BURST - 1)) ? ROW_DONE : SCAN;
            end
         end
         ROW_DONE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         row_sel_q <= '0;
         y_q       <= '0;
         settle_q  <= '0;
         served_q  <= '0;
         burst_q   <= '0;
         ack_q     <= '0;
         evt_x_q   <= '0;
         evt_y_q   <= '0;
         evt_ts_q  <= '0;
         ts_cnt    <= '0;
         rr_ptr_q  <= YW'(ROWS - 1);
      end else begin
         state_q <= state_d;
         ts_cnt  <= ts_cnt + TS_W'(1);
         ack_q   <= '0;
         if (load_row) begin
            row_sel_q <= row_grant;
            y_q       <= grant_idx;
            settle_q  <= SW'(SETTLE_CYC - 1);
         end else if (state_q == SETTLE) begin
            settle_q <= settle_q - SW'(1);
         end
         if (capture) begin
            evt_x_q  <= pick_x;
            evt_y_q  <= y_q;
            evt_ts_q <= ts_cnt;
         end
         if (handshake) begin
            served_q[evt_x_q] <= 1'b1;
            ack_q             <= COLS'(1) << evt_x_q;
            burst_q           <= burst_q + BW'(1);
         end
         if (state_q == ROW_DONE) begin
            row_sel_q <= '0;
            served_q  <= '0;
            burst_q   <= '0;
            rr_ptr_q  <= y_q;
         end
      end
   end

   assign row_sel_o   = row_sel_q;
   assign pixel_ack_o = ack_q;
   assign evt_valid_o = (state_q == EMIT);
   assign evt_x_o     = evt_x_q;
   assign evt_y_o     = evt_y_q;
   assign evt_ts_o    = evt_ts_q;
   assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_event_readout_ctrl.sv
// Scoreboard bench for event_readout_ctrl: pixel-array model, event queue, negedge monitor.
module tb_event_readout_ctrl;
   localparam int ROWS       = 8;
   localparam int COLS       = 8;
   localparam int SETTLE_CYC = 2;
   localparam int MAX_BURST  = 4;
   localparam int TS_W       = 16;
   localparam int XW         = $clog2(COLS);
   localparam int YW         = $clog2(ROWS);

   logic            clk_i = 1'b0;
   logic            reset_i, enable_i, evt_ready_i;
   logic [ROWS-1:0] row_req_i, row_sel_o;
   logic [COLS-1:0] col_req_i, pixel_ack_o;
   logic            evt_valid_o, busy_o;
   logic [XW-1:0]   evt_x_o;
   logic [YW-1:0]   evt_y_o;
   logic [TS_W-1:0] evt_ts_o;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } evt_t;

   logic [COLS-1:0] pend [ROWS];
   logic            ovr_en, rand_ready;
   logic [ROWS-1:0] ovr_row;
   logic [COLS-1:0] ovr_col;
   evt_t            exp_q [$];
   int              total = 0, bad = 0, hs_count = 0, mptr;
   logic [TS_W-1:0] tb_ts;

   always #5 clk_i = ~clk_i;

   event_readout_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SETTLE_CYC), .MAX_BURST(MAX_BURST), .TS_W(TS_W)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .row_req_i(row_req_i), .col_req_i(col_req_i), .row_sel_o(row_sel_o),
      .pixel_ack_o(pixel_ack_o), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
      .evt_x_o(evt_x_o), .evt_y_o(evt_y_o), .evt_ts_o(evt_ts_o), .busy_o(busy_o)
   );

   // Pixel array: a row requests while any pixel pends; columns appear for the selected row.
   always_comb begin
      col_req_i = '0;
      row_req_i = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_sel_o[r]) col_req_i = col_req_i | pend[r];
         if (pend[r] != '0) row_req_i[r] = 1'b1;
      end
      if (ovr_en) begin
         row_req_i = ovr_row;
         col_req_i = (row_sel_o != '0) ? ovr_col : '0;
      end
   end

   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) tb_ts <= '0;
      else         tb_ts <= tb_ts + 16'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic            prev_valid, prev_hs;
   logic [COLS-1:0] exp_ack;
   logic [XW-1:0]   hold_x;
   logic [YW-1:0]   hold_y;
   logic [TS_W-1:0] hold_ts;

   always @(negedge clk_i) begin
      evt_t e;
      if (reset_i) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
         exp_ack    = '0;
      end else begin
         if (exp_ack != '0 || pixel_ack_o != '0) chk("pixel_ack", 32'(pixel_ack_o), 32'(exp_ack));
         if (pixel_ack_o != '0 && !ovr_en)
            for (int r = 0; r < ROWS; r++)
               if (row_sel_o[r]) pend[r] = pend[r] & ~pixel_ack_o;
         exp_ack = '0;
         if (evt_valid_o) begin
            if (!prev_valid || prev_hs) begin
               chk("evt_ts", 32'(evt_ts_o), 32'(TS_W'(tb_ts - 16'd1)));
               hold_x  = evt_x_o;
               hold_y  = evt_y_o;
               hold_ts = evt_ts_o;
            end else begin
               chk("hold_x", 32'(evt_x_o), 32'(hold_x));
               chk("hold_y", 32'(evt_y_o), 32'(hold_y));
               chk("hold_ts", 32'(evt_ts_o), 32'(hold_ts));
            end
         end
         prev_valid = evt_valid_o;
         prev_hs    = evt_valid_o && evt_ready_i;
         if (prev_hs) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL evt_unexpected: got x=%0d y=%0d expected no event", evt_x_o, evt_y_o);
               exp_ack = COLS'(1) << evt_x_o;
            end else begin
               e = exp_q.pop_front();
               chk("evt_x", 32'(evt_x_o), 32'(e.x));
               chk("evt_y", 32'(evt_y_o), 32'(e.y));
               exp_ack = COLS'(1) << e.x;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk_i);
      #1;
      if (rand_ready) evt_ready_i = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

   task automatic push_evt(input int x, input int y);
      evt_t e;
      e.x = XW'(x);
      e.y = YW'(y);
      exp_q.push_back(e);
   endtask

   // Reference: visit rows round-robin after the last one, take up to MAX_BURST lowest columns.
   task automatic model_drain();
      logic [COLS-1:0] m [ROWS];
      int r, n, guard, c;
      for (int i = 0; i < ROWS; i++) m[i] = pend[i];
      guard = 0;
      while (guard < 1000) begin
         r = -1;
         for (int k = 1; k <= ROWS; k++) begin
            c = (mptr + k) % ROWS;
            if (r < 0 && m[c] != '0) r = c;
         end
         if (r < 0) break;
         n = 0;
         for (int col = 0; col < COLS; col++)
            if (m[r][col] && n < MAX_BURST) begin
               push_evt(col, r);
               m[r][col] = 1'b0;
               n++;
            end
         mptr = r;
         guard++;
      end
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      enable_i    = 1'b1;
      evt_ready_i = 1'b1;
      rand_ready  = 1'b0;
      ovr_en      = 1'b0;
      ovr_row     = '0;
      ovr_col     = '0;
      for (int r = 0; r < ROWS; r++) pend[r] = '0;
      exp_q.delete();
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
      mptr = ROWS - 1;
   endtask

   task automatic wait_done(input string name, input int budget, output int visits);
      int n;
      logic [ROWS-1:0] prev;
      n      = 0;
      visits = 0;
      prev   = row_sel_o;
      while ((busy_o || exp_q.size() != 0) && n < budget) begin
         @(negedge clk_i);
         n++;
         if (row_sel_o != '0 && prev == '0) visits++;
         prev = row_sel_o;
      end
      repeat (4) @(negedge clk_i);
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle with none pending",
                  name, busy_o, exp_q.size());
      end
   endtask

   initial begin : main
      int n, first, vis, hs0, seen;
      logic [ROWS-1:0] prev;
      logic [ROWS-1:0] rr_exp [4];
      logic [COLS-1:0] all_pend;
      rr_exp[0] = 8'h01; rr_exp[1] = 8'h80; rr_exp[2] = 8'h01; rr_exp[3] = 8'h80;

      // Reset values, asynchronous
      reset_i = 1'b1; enable_i = 1'b1; evt_ready_i = 1'b1; rand_ready = 1'b0;
      ovr_en = 1'b0; ovr_row = '0; ovr_col = '0;
      for (int r = 0; r < ROWS; r++) pend[r] = '0;
      #3;
      chk("rst_row_sel", 32'(row_sel_o), 0);
      chk("rst_ack", 32'(pixel_ack_o), 0);
      chk("rst_valid", 32'(evt_valid_o), 0);
      chk("rst_x", 32'(evt_x_o), 0);
      chk("rst_y", 32'(evt_y_o), 0);
      chk("rst_ts", 32'(evt_ts_o), 0);
      chk("rst_busy", 32'(busy_o), 0);

      // Single row, ready high
      do_reset();
      pend[2] = 8'h12;
      push_evt(1, 2);
      push_evt(4, 2);
      n = 0;
      first = -1;
      repeat (12) begin
         @(posedge clk_i);
         n++;
         @(negedge clk_i);
         if (n == 1) chk("single_row_sel_c1", 32'(row_sel_o), 32'h04);
         if (evt_valid_o && first < 0) first = n;
      end
      chk("single_first_valid_cycle", 32'(first), 32'(SETTLE_CYC + 2));
      wait_done("single", 50, vis);
      chk("single_busy_low", 32'(busy_o), 0);

      // Round-robin between rows 0 and 7
      do_reset();
      ovr_en = 1'b1; ovr_row = 8'h81; ovr_col = 8'h01;
      push_evt(0, 0); push_evt(0, 7); push_evt(0, 0); push_evt(0, 7);
      vis = 0; n = 0; prev = '0;
      while (vis < 4 && n < 200) begin
         @(negedge clk_i);
         n++;
         if (row_sel_o != '0 && prev == '0) begin
            chk("rr_visit", 32'(row_sel_o), 32'(rr_exp[vis]));
            vis++;
         end
         prev = row_sel_o;
      end
      @(posedge clk_i);
      #1 ovr_row = '0;
      chk("rr_visit_count", 32'(vis), 4);
      wait_done("rr", 100, vis);

      // Burst limit: two visits of four events
      do_reset();
      pend[3] = 8'hFF;
      for (int x = 0; x < COLS; x++) push_evt(x, 3);
      wait_done("burst", 200, vis);
      chk("burst_visits", 32'(vis), 2);
      chk("burst_pend_clear", 32'(pend[3]), 0);

      // Back-pressure for 5 cycles
      do_reset();
      evt_ready_i = 1'b0;
      pend[5] = 8'h08;
      push_evt(3, 5);
      n = 0;
      while (!evt_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("bp_valid_seen", 32'(evt_valid_o), 1);
      repeat (4) begin
         @(posedge clk_i);
         @(negedge clk_i);
         chk("bp_valid_held", 32'(evt_valid_o), 1);
         chk("bp_no_ack", 32'(pixel_ack_o), 0);
      end
      @(posedge clk_i);
      #1 evt_ready_i = 1'b1;
      wait_done("bp", 50, vis);

      // Stuck request: emitted once per visit
      do_reset();
      ovr_en = 1'b1; ovr_row = 8'h02; ovr_col = 8'h01;
      push_evt(0, 1);
      hs0 = hs_count; seen = 0; n = 0; vis = 0; prev = '0;
      while (n < 100) begin
         @(negedge clk_i);
         n++;
         if (row_sel_o != '0 && prev == '0) vis++;
         prev = row_sel_o;
         if (busy_o) seen = 1;
         else if (seen != 0) begin
            ovr_row = '0;
            break;
         end
      end
      repeat (4) @(negedge clk_i);
      chk("stuck_finished", 32'(n < 100), 1);
      chk("stuck_visits", 32'(vis), 1);
      chk("stuck_events", 32'(hs_count - hs0), 1);

      // Reset during EMIT
      do_reset();
      evt_ready_i = 1'b0;
      pend[4] = 8'h01;
      push_evt(0, 4);
      n = 0;
      while (!evt_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("abort_valid_seen", 32'(evt_valid_o), 1);
      @(posedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      chk("abort_row_sel", 32'(row_sel_o), 0);
      chk("abort_valid", 32'(evt_valid_o), 0);
      chk("abort_ack", 32'(pixel_ack_o), 0);
      chk("abort_x", 32'(evt_x_o), 0);
      chk("abort_ts", 32'(evt_ts_o), 0);
      chk("abort_busy", 32'(busy_o), 0);
      do_reset();
      repeat (3) begin
         @(negedge clk_i);
         chk("abort_no_ack_after", 32'(pixel_ack_o), 0);
      end

      // Enable dropped during SETTLE
      do_reset();
      pend[6] = 8'h01;
      hs0 = hs_count;
      n = 0;
      while (row_sel_o == '0 && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("en_row_sel", 32'(row_sel_o), 32'h40);
      @(posedge clk_i);
      #1 enable_i = 1'b0;
      n = 0;
      while (busy_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("en_idle", 32'(busy_o), 0);
      chk("en_row_sel_clear", 32'(row_sel_o), 0);
      repeat (4) @(negedge clk_i);
      chk("en_no_event", 32'(hs_count - hs0), 0);
      chk("en_no_revisit", 32'(busy_o), 0);

      // Randomized drains with random back-pressure
      do_reset();
      rand_ready = 1'b1;
      for (int ph = 0; ph < 6; ph++) begin
         @(posedge clk_i);
         #1;
         for (int r = 0; r < ROWS; r++)
            pend[r] = ($urandom_range(0, 2) == 0) ? '0 : COLS'($urandom);
         model_drain();
         wait_done("rand", 2000, vis);
         all_pend = '0;
         for (int r = 0; r < ROWS; r++) all_pend = all_pend | pend[r];
         chk("rand_pend_clear", 32'(all_pend), 0);
      end
      rand_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
